// File: rtl/param_regfile_if.sv
// param_regfile_if: write/read bus of the parametrised register file.
// master drives the write strobe and the addresses; slave returns read data.
interface param_regfile_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wrenable;
    logic [ADDR_WIDTH-1:0] wraddr;
    logic [WIDTH-1:0]      wrdata;
    logic [ADDR_WIDTH-1:0] rdaddr1;
    logic [ADDR_WIDTH-1:0] rdaddr2;
    logic [WIDTH-1:0]      rddata1;
    logic [WIDTH-1:0]      rddata2;

    modport master (
        output wrenable, wraddr, wrdata, rdaddr1, rdaddr2,
        input  rddata1, rddata2
    );

    modport slave (
        input  wrenable, wraddr, wrdata, rdaddr1, rdaddr2,
        output rddata1, rddata2
    );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: 2**ADDR_WIDTH x WIDTH register file, one synchronous write
// port, two combinational read ports, entry 0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding of wrdata to a
// read port addressing the entry being written in the same cycle.
// WIDTH/ADDR_WIDTH must match the parameters of the connected interface.
module param_regfile #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic             clk,
    input logic             reset,
    param_regfile_if.slave  rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is never stored; the array starts at index 1.
    logic [WIDTH-1:0] mem_q [1:DEPTH-1];
    logic [WIDTH-1:0] mem_d [1:DEPTH-1];
    logic             wr_hit;

    assign wr_hit = rf.wrenable && (rf.wraddr != '0);

    // Next-state contents: the addressed entry takes wrdata, others hold.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (wr_hit && (rf.wraddr == ADDR_WIDTH'(i))) begin
                mem_d[i] = rf.wrdata;
            end
        end
    end

    // Storage update; reset clears every entry immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port 1: address decode over stored entries, entry 0 reads zero.
    always_comb begin
        rf.rddata1 = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rf.rdaddr1 == ADDR_WIDTH'(i)) begin
                rf.rddata1 = mem_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_hit && (rf.rdaddr1 == rf.wraddr)) begin
            rf.rddata1 = rf.wrdata;
        end
`else
`endif
    end

    // Read port 2: independent copy of the port 1 decode.
    always_comb begin
        rf.rddata2 = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rf.rdaddr2 == ADDR_WIDTH'(i)) begin
                rf.rddata2 = mem_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_hit && (rf.rdaddr2 == rf.wraddr)) begin
            rf.rddata2 = rf.wrdata;
        end
`else
`endif
    end
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: scoreboard bench for param_regfile, default 32x32
// instance plus an 8-bit x 4-entry instance.
module tb_param_regfile;
    logic clk;
    logic reset;

    param_regfile_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();
    param_regfile_if #(.WIDTH(8),  .ADDR_WIDTH(2)) bus_s ();

    param_regfile #(.WIDTH(32), .ADDR_WIDTH(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    param_regfile #(.WIDTH(8), .ADDR_WIDTH(2)) u_small (
        .clk   (clk),
        .reset (reset),
        .rf    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          sel;   // 0/1: main port 1/2, 2/3: small port 1/2
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q [$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Compare every queued expectation against the settled outputs.
    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = bus.rddata1;
                1:       obs = bus.rddata2;
                2:       obs = {24'h0, bus_s.rddata1};
                default: obs = {24'h0, bus_s.rddata2};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
        bus.rdaddr1 = a1;
        bus.rdaddr2 = a2;
        push({tag, "_p1"}, 0, e1);
        push({tag, "_p2"}, 1, e2);
        drain();
    endtask

    task automatic rd_s(input string tag, input logic [1:0] a1, input logic [1:0] a2,
                        input logic [7:0] e1, input logic [7:0] e2);
        bus_s.rdaddr1 = a1;
        bus_s.rdaddr2 = a2;
        push({tag, "_p1"}, 2, {24'h0, e1});
        push({tag, "_p2"}, 3, {24'h0, e2});
        drain();
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wrenable = en;
        bus.wraddr   = a;
        bus.wrdata   = d;
        @(posedge clk);
        #1;
        bus.wrenable = 1'b0;
    endtask

    task automatic wr_s(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_s.wrenable = 1'b1;
        bus_s.wraddr   = a;
        bus_s.wrdata   = d;
        @(posedge clk);
        #1;
        bus_s.wrenable = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.wrenable  = 1'b0;
        bus.wraddr    = '0;
        bus.wrdata    = '0;
        bus.rdaddr1   = '0;
        bus.rdaddr2   = '0;
        bus_s.wrenable = 1'b0;
        bus_s.wraddr   = '0;
        bus_s.wrdata   = '0;
        bus_s.rdaddr1  = '0;
        bus_s.rdaddr2  = '0;

        repeat (2) @(posedge clk);
        rd("reset_state", 5'd0, 5'd5, 32'h0, 32'h0);

        // Write attempted while reset is held must be ignored.
        wr(1'b1, 5'd4, 32'hCAFE_F00D);
        rd("write_in_reset", 5'd4, 5'd4, 32'h0, 32'h0);

        // Release reset between edges; first write on the next edge lands.
        @(negedge clk);
        reset = 1'b0;
        wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        rd("first_write", 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);

        // Asynchronous reset pulse between edges clears immediately.
        @(negedge clk);
        bus.rdaddr1 = 5'd5;
        #1;
        reset = 1'b1;
        rd("async_reset", 5'd5, 5'd5, 32'h0, 32'h0);
        reset = 1'b0;

        // Basic writes on consecutive edges and dual-port reads.
        wr(1'b1, 5'd7, 32'h1234_5678);
        wr(1'b1, 5'd31, 32'hA5A5_A5A5);
        rd("basic", 5'd7, 5'd31, 32'h1234_5678, 32'hA5A5_A5A5);
        rd("same_addr", 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);

        // Entry 0 discards writes.
        wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        rd("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

        // Enable gating.
        wr(1'b1, 5'd3, 32'h11);
        wr(1'b0, 5'd3, 32'h22);
        rd("enable_gate", 5'd3, 5'd7, 32'h11, 32'h1234_5678);

        // Same-cycle read of the entry being written.
        wr(1'b1, 5'd9, 32'h1);
        @(negedge clk);
        bus.wrenable = 1'b1;
        bus.wraddr   = 5'd9;
        bus.wrdata   = 32'h2;
        rd("rw_before", 5'd9, 5'd3, BYPASS ? 32'h2 : 32'h1, 32'h11);
        @(posedge clk);
        #1;
        bus.wrenable = 1'b0;
        rd("rw_after", 5'd9, 5'd9, 32'h2, 32'h2);

        // Back-to-back writes: last edge wins.
        wr(1'b1, 5'd10, 32'hAAAA_0001);
        rd("b2b_first", 5'd10, 5'd0, 32'hAAAA_0001, 32'h0);
        wr(1'b1, 5'd10, 32'hBBBB_0002);
        rd("b2b_last", 5'd10, 5'd10, 32'hBBBB_0002, 32'hBBBB_0002);

        // A write to entry 0 never forwards.
        @(negedge clk);
        bus.wrenable = 1'b1;
        bus.wraddr   = 5'd0;
        bus.wrdata   = 32'h5555_5555;
        rd("zero_nofwd", 5'd0, 5'd0, 32'h0, 32'h0);
        bus.wrenable = 1'b0;

        // Small instance: 8-bit, 4 entries.
        wr_s(2'd1, 8'hFF);
        wr_s(2'd2, 8'hFF);
        wr_s(2'd3, 8'hFF);
        rd_s("small_12", 2'd1, 2'd2, 8'hFF, 8'hFF);
        rd_s("small_30", 2'd3, 2'd0, 8'hFF, 8'h00);
        wr_s(2'd0, 8'hFF);
        rd_s("small_zero", 2'd0, 2'd0, 8'h00, 8'h00);

        // No forwarding while reset is asserted; contents cleared.
        @(negedge clk);
        reset        = 1'b1;
        bus.wrenable = 1'b1;
        bus.wraddr   = 5'd9;
        bus.wrdata   = 32'h3;
        rd("reset_nofwd", 5'd9, 5'd31, 32'h0, 32'h0);
        rd_s("small_reset", 2'd1, 2'd3, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        bus.wrenable = 1'b0;
        rd("reset_edge", 5'd9, 5'd7, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
